rf_wb_arbiter: RTL and testbench

Write-side client of the integer register file. Merges single-cycle ALU results and out-of-order-latency load returns into the register file's single write port (wen/index_rd/data_rd). Buffers load returns in a small FIFO. Keeps a per-register pending scoreboard so decode can stall on RAW and WAW hazards against in-flight loads.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_wb_arbiter_if.sv | 55 +++++
 rtl/wb_fifo.sv | 52 +++++
 rtl/rf_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the integer register-file write side.
package rf_pkg;

    localparam int XLEN      = 64;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;
    localparam int LQ_DEPTH  = 4;

    // One register-file write: destination index plus data.
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Handshake and write-port bundle between decode/ALU/memory and the write arbiter.
interface rf_wb_arbiter_if
    import rf_pkg::*;
#(
    parameter int XLEN = rf_pkg::XLEN,
    parameter int NREG = rf_pkg::NREG
);

    logic                 alu_valid;
    logic                 alu_ready;
    logic [REG_IDX_W-1:0] alu_rd;
    logic [XLEN-1:0]      alu_data;

    logic                 ld_issue_valid;
    logic                 ld_issue_ready;
    logic [REG_IDX_W-1:0] ld_issue_rd;

    logic                 ld_resp_valid;
    logic                 ld_resp_ready;
    logic [REG_IDX_W-1:0] ld_resp_rd;
    logic [XLEN-1:0]      ld_resp_data;

    logic [REG_IDX_W-1:0] rs1_idx;
    logic [REG_IDX_W-1:0] rs2_idx;
    logic                 rs1_busy;
    logic                 rs2_busy;

    logic                 wen;
    logic [REG_IDX_W-1:0] index_rd;
    logic [XLEN-1:0]      data_rd;
    logic [NREG-1:0]      pending;

    // Producer/consumer side: ALU, decode and memory.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue_valid, ld_issue_rd,
        output ld_resp_valid, ld_resp_rd, ld_resp_data,
        output rs1_idx, rs2_idx,
        input  alu_ready, ld_issue_ready, ld_resp_ready,
        input  rs1_busy, rs2_busy,
        input  wen, index_rd, data_rd, pending
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue_valid, ld_issue_rd,
        input  ld_resp_valid, ld_resp_rd, ld_resp_data,
        input  rs1_idx, rs2_idx,
        output alu_ready, ld_issue_ready, ld_resp_ready,
        output rs1_busy, rs2_busy,
        output wen, index_rd, data_rd, pending
    );

endinterface

// File: rtl/wb_fifo.sv
// Small first-word-fall-through FIFO holding load returns until the write port is free.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr;

    // Pointer and occupancy tracking; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and count alone decide what is valid.
        if (push) mem[wptr] <= din;
    end

    assign dout  = mem[rptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges ALU results and buffered load returns onto the single register-file
// write port and tracks which registers still await load data.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN     = rf_pkg::XLEN,
    parameter int LQ_DEPTH = rf_pkg::LQ_DEPTH,
    parameter int NREG     = rf_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst,
    rf_wb_arbiter_if.slave  bus
);

    localparam int CW = $clog2(LQ_DEPTH) + 1;
    localparam int FW = REG_IDX_W + XLEN;

    logic [FW-1:0]        fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [REG_IDX_W-1:0] head_rd;
    logic [XLEN-1:0]      head_data;

    logic                 sel_fifo;
    logic                 sel_alu;
    logic                 wr_en;
    logic [REG_IDX_W-1:0] wr_rd;
    logic [XLEN-1:0]      wr_data;

    logic                 set_en;
    logic                 clr_en;
    logic [NREG-1:0]      pending_q;
    logic [NREG-1:0]      pending_next;

    logic                 wen_q;
    logic [REG_IDX_W-1:0] index_rd_q;
    logic [XLEN-1:0]      data_rd_q;

    wb_fifo #(
        .DEPTH (LQ_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({bus.ld_resp_rd, bus.ld_resp_data}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_rd   = fifo_head[FW-1 -: REG_IDX_W];
    assign head_data = fifo_head[XLEN-1:0];

    // A full FIFO outranks the ALU so loads cannot starve; otherwise ALU first.
    assign sel_fifo  = ~fifo_empty & (fifo_full | ~bus.alu_valid);
    assign sel_alu   = bus.alu_valid & ~fifo_full;
    assign fifo_pop  = sel_fifo;

    assign bus.alu_ready     = ~fifo_full;
    assign bus.ld_resp_ready = ~fifo_full | fifo_pop;
    assign fifo_push         = bus.ld_resp_valid & bus.ld_resp_ready;

    // Select the source for next cycle's write; x0 targets are consumed silently.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        wr_rd   = '0;
        wr_data = '0;
        if (sel_fifo) begin
            wr_rd   = head_rd;
            wr_data = head_data;
        end else if (sel_alu) begin
            wr_rd   = bus.alu_rd;
            wr_data = bus.alu_data;
        end
        wr_en = (sel_fifo | sel_alu) & (wr_rd != '0);
    end

    assign bus.ld_issue_ready = ~pending_q[bus.ld_issue_rd] | (bus.ld_issue_rd == '0);
    assign set_en = bus.ld_issue_valid & bus.ld_issue_ready & (bus.ld_issue_rd != '0);
    assign clr_en = sel_fifo & (head_rd != '0);

    // Scoreboard update: clear on load commit, then set on issue so a set wins.
    always_comb begin
        pending_next = pending_q;
        if (clr_en) pending_next[head_rd] = 1'b0;
        if (set_en) pending_next[bus.ld_issue_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // Registered write port and scoreboard state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q      <= 1'b0;
            index_rd_q <= '0;
            data_rd_q  <= '0;
            pending_q  <= '0;
        end else begin
            wen_q     <= wr_en;
            pending_q <= pending_next;
            if (wr_en) begin
                index_rd_q <= wr_rd;
                data_rd_q  <= wr_data;
            end
        end
    end

    assign bus.wen      = wen_q;
    assign bus.index_rd = index_rd_q;
    assign bus.data_rd  = data_rd_q;
    assign bus.pending  = pending_q;

    // Decode sees a register free in the same cycle its load data is committed.
    assign bus.rs1_busy = pending_q[bus.rs1_idx] & ~(clr_en & (head_rd == bus.rs1_idx));
    assign bus.rs2_busy = pending_q[bus.rs2_idx] & ~(clr_en & (head_rd == bus.rs2_idx));

    // Protocol checks on the surrounding pipeline.
    a_alu_to_pending: assert property (@(posedge clk) disable iff (rst)
        (bus.alu_valid && bus.alu_ready && bus.alu_rd != '0) |-> !pending_q[bus.alu_rd]);

    a_resp_not_pending: assert property (@(posedge clk) disable iff (rst)
        (bus.ld_resp_valid && bus.ld_resp_ready && bus.ld_resp_rd != '0) |-> pending_q[bus.ld_resp_rd]);

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        fifo_count <= CW'(LQ_DEPTH));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for the register-file write arbiter.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic clk;
    logic rst;

    rf_wb_arbiter_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

    rf_wb_arbiter #(
        .XLEN     (XLEN),
        .LQ_DEPTH (4),
        .NREG     (NREG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    wb_req_t got_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid      = 1'b0;
        bus.alu_rd         = '0;
        bus.alu_data       = '0;
        bus.ld_issue_valid = 1'b0;
        bus.ld_issue_rd    = '0;
        bus.ld_resp_valid  = 1'b0;
        bus.ld_resp_rd     = '0;
        bus.ld_resp_data   = '0;
        bus.rs1_idx        = '0;
        bus.rs2_idx        = '0;
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.ld_issue_valid = 1'b1;
        bus.ld_issue_rd    = rd;
        tick();
        bus.ld_issue_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_wen", bus.wen, 0);
        check("rst_index", bus.index_rd, 0);
        check("rst_data", bus.data_rd, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_resp_ready", bus.ld_resp_ready, 1);
        check("rst_alu_ready", bus.alu_ready, 1);

        // ALU only: one-cycle write one cycle later.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'h1234;
        #1 check("alu_ready", bus.alu_ready, 1);
        tick(); idle(); #1;
        check("alu_wen", bus.wen, 1);
        check("alu_index", bus.index_rd, 5);
        check("alu_data", bus.data_rd, 64'h1234);
        tick();
        check("alu_one_shot", bus.wen, 0);

        // Scoreboard on rd=9.
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd9;
        #1 check("issue9_ready", bus.ld_issue_ready, 1);
        tick(); #1;
        check("pending9_set", bus.pending, 32'h0000_0200);
        check("issue9_again_ready", bus.ld_issue_ready, 0);
        tick(); idle();
        bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'd9; bus.ld_resp_data = 64'hAA; bus.rs1_idx = 5'd9;
        #1 check("rs1_busy_pushed", bus.rs1_busy, 1);
        tick(); bus.ld_resp_valid = 1'b0; #1;
        check("rs1_busy_bypass", bus.rs1_busy, 0);
        check("pending9_still", bus.pending, 32'h0000_0200);
        tick(); #1;
        check("ld9_wen", bus.wen, 1);
        check("ld9_index", bus.index_rd, 9);
        check("ld9_data", bus.data_rd, 64'hAA);
        check("pending9_clr", bus.pending, 0);
        tick(); idle();
        check("ld9_no_dup", bus.wen, 0);

        // Priority: ALU and load response in the same cycle.
        issue(5'd7);
        bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'd7; bus.ld_resp_data = 64'h77;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'h33;
        tick(); idle(); #1;
        check("prio_first_index", bus.index_rd, 3);
        check("prio_first_data", bus.data_rd, 64'h33);
        tick();
        check("prio_second_wen", bus.wen, 1);
        check("prio_second_index", bus.index_rd, 7);
        check("prio_second_data", bus.data_rd, 64'h77);
        check("prio_pending", bus.pending, 0);

        // Starvation: fill the FIFO while the ALU stream holds the port.
        for (int r = 11; r <= 14; r++) issue(5'(r));
        check("starve_pending", bus.pending, 32'h0000_7800);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 64'h2000;
        for (int k = 0; k < 4; k++) begin
            bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'(11 + k); bus.ld_resp_data = 64'h110 + 64'(k);
            tick();
        end
        bus.ld_resp_valid = 1'b0; #1;
        check("starve_alu_flow", bus.index_rd, 20);
        check("full_alu_ready", bus.alu_ready, 0);
        check("full_resp_ready", bus.ld_resp_ready, 1);
        tick(); #1;
        check("starve_head_index", bus.index_rd, 11);
        check("starve_head_data", bus.data_rd, 64'h110);
        check("starve_alu_ready_back", bus.alu_ready, 1);
        tick(); bus.alu_valid = 1'b0;
        check("starve_alu_again", bus.index_rd, 20);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("starve_drain_index", bus.index_rd, 64'(12 + k));
            check("starve_drain_data", bus.data_rd, 64'h111 + 64'(k));
        end
        tick(); idle();
        check("starve_done_wen", bus.wen, 0);
        check("starve_pending_clr", bus.pending, 0);

        // Issue of rd=4 while its load data is being committed.
        issue(5'd4);
        bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'd4; bus.ld_resp_data = 64'h44;
        tick(); idle();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd4; bus.rs2_idx = 5'd4;
        #1;
        check("coll_issue_ready", bus.ld_issue_ready, 0);
        check("coll_rs2_busy", bus.rs2_busy, 0);
        tick(); #1;
        check("coll_wen", bus.wen, 1);
        check("coll_index", bus.index_rd, 4);
        check("coll_data", bus.data_rd, 64'h44);
        check("coll_issue_ready_next", bus.ld_issue_ready, 1);
        tick(); idle();
        check("coll_pending4", bus.pending, 32'h0000_0010);

        // x0 from either source is swallowed.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 64'hDEAD;
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd0;
        #1 check("x0_issue_ready", bus.ld_issue_ready, 1);
        tick(); idle();
        check("x0_alu_wen", bus.wen, 0);
        check("x0_pending", bus.pending, 32'h0000_0010);
        bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'd0; bus.ld_resp_data = 64'hBEEF;
        tick(); idle();
        tick();
        check("x0_resp_wen", bus.wen, 0);
        tick();
        check("x0_resp_late", bus.wen, 0);
        check("x0_pending_after", bus.pending, 32'h0000_0010);

        // Ten back-to-back returns: in order, across pointer wrap.
        for (int i = 0; i < 10; i++) issue(5'(16 + i));
        check("wrap_pending", bus.pending, 32'h03FF_0010);
        for (int i = 0; i < 14; i++) begin
            if (i < 10) begin
                bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'(16 + i); bus.ld_resp_data = 64'h5000 + 64'(i);
            end else begin
                bus.ld_resp_valid = 1'b0;
            end
            tick();
            if (bus.wen) got_q.push_back('{rd: bus.index_rd, data: bus.data_rd});
        end
        check("wrap_count", got_q.size(), 10);
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            check("wrap_rd", got_q[i].rd, 64'(16 + i));
            check("wrap_data", got_q[i].data, 64'h5000 + 64'(i));
        end
        check("wrap_pending_clr", bus.pending, 32'h0000_0010);

        // Reset with three entries still buffered.
        bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'd4; bus.ld_resp_data = 64'h4444;
        tick(); idle(); tick(); tick();
        check("pre_rst_pending", bus.pending, 0);
        for (int r = 1; r <= 3; r++) issue(5'(r));
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 64'hA0;
        for (int r = 1; r <= 3; r++) begin
            bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'(r); bus.ld_resp_data = 64'hC0 + 64'(r);
            tick();
        end
        bus.ld_resp_valid = 1'b0; #1;
        check("mid_pending", bus.pending, 32'h0000_000E);
        check("mid_index_alu", bus.index_rd, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0; idle(); #1;
        check("mid_rst_wen", bus.wen, 0);
        check("mid_rst_pending", bus.pending, 0);
        check("mid_rst_resp_ready", bus.ld_resp_ready, 1);
        check("mid_rst_alu_ready", bus.alu_ready, 1);
        tick();
        check("mid_rst_fifo_empty1", bus.wen, 0);
        tick();
        check("mid_rst_fifo_empty2", bus.wen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
